// File: rtl/id_ex_stage_pkg.sv
// Shared types for the ID/EX pipeline register: operand/register types, the EX payload struct
// and the bubble-state enum.
package id_ex_stage_pkg;

    localparam int XLEN                 = 32;
    localparam int CTRL_W_DEF           = 16;
    localparam int LOAD_USE_BUBBLES_DEF = 1;

    typedef logic [XLEN-1:0] data_t;
    typedef logic [4:0]      r_t;
    typedef logic [1:0]      bub_cnt_t;

    localparam data_t ZERO = '0;
    localparam r_t    NULL = '0;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_BUBBLE = 1'b1
    } bub_state_e;

    // The control bundle is parameter-sized, so it is registered beside this struct.
    typedef struct packed {
        data_t       pc;
        logic [31:0] instr;
        data_t       imm;
        r_t          rd_addr;
        logic        rd_wren;
        logic        is_load;
        r_t          rs1_addr;
        r_t          rs2_addr;
        logic        rs1_rden;
        logic        rs2_rden;
        data_t       rs1_data;
        data_t       rs2_data;
    } id_ex_t;

    function automatic logic reads_reg(input r_t src, input logic rden, input r_t dst);
        return rden && (src == dst);
    endfunction

endpackage

// File: rtl/id_ex_stage_operand_snoop.sv
// Keeps one held EX operand current by replacing it with a matching writeback result.
module operand_snoop
    import id_ex_stage_pkg::*;
(
    input  r_t    src_addr,
    input  logic  src_rden,
    input  data_t held_data,
    input  logic  wb_rd_wren,
    input  r_t    wb_rd_addr,
    input  data_t wb_rd_data,
    output data_t snoop_data
);

    always_comb begin
        snoop_data = held_data;
        if (wb_rd_wren && (wb_rd_addr != NULL) && reads_reg(src_addr, src_rden, wb_rd_addr)) begin
            snoop_data = wb_rd_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, writeback snooping while holding and
// EX flush. Optional performance counters are enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int LOAD_USE_BUBBLES = LOAD_USE_BUBBLES_DEF,
    parameter int CTRL_W           = CTRL_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [31:0]       id_instr,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [4:0]        id_rd_addr,
    input  logic              id_rd_wren,
    input  logic              id_is_load,
    input  logic [4:0]        id_rs1_addr,
    input  logic [4:0]        id_rs2_addr,
    input  logic              id_rs1_rden,
    input  logic              id_rs2_rden,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic              wb_rd_wren,
    input  logic [4:0]        wb_rd_addr,
    input  logic [XLEN-1:0]   wb_rd_data,
    input  logic              ex_flush,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [31:0]       ex_instr,
    output logic [XLEN-1:0]   ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [4:0]        ex_rd_addr,
    output logic              ex_rd_wren,
    output logic              ex_is_load,
    output logic [4:0]        ex_rs1_addr,
    output logic [4:0]        ex_rs2_addr,
    output logic              ex_rs1_rden,
    output logic              ex_rs2_rden,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]       perf_bubble_cnt,
    output logic [31:0]       perf_flush_cnt
`endif
);

    id_ex_t             ex_q, ex_d;
    logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
    logic               valid_q, valid_d;
    bub_cnt_t           bub_cnt_q, bub_cnt_d;
    bub_state_e         state_q, state_d;

    logic               load_hazard;
    logic               capture;
    logic               handoff;
    logic               hold;
    logic               load_leaves;
    data_t              rs1_snoop;
    data_t              rs2_snoop;

    assign load_hazard = valid_q && ex_q.is_load && ex_q.rd_wren && (ex_q.rd_addr != NULL) &&
                         (reads_reg(id_rs1_addr, id_rs1_rden, ex_q.rd_addr) ||
                          reads_reg(id_rs2_addr, id_rs2_rden, ex_q.rd_addr));

    assign id_ready    = ex_flush ||
                         ((!valid_q || ex_ready) && !load_hazard && (state_q == ST_RUN));
    assign capture     = id_valid && id_ready && !ex_flush;
    assign handoff     = valid_q && ex_ready;
    assign hold        = valid_q && !ex_ready;
    // The dependent instruction is waiting in ID as the load moves on: open a bubble window.
    assign load_leaves = handoff && load_hazard && id_valid;

    operand_snoop u_snoop_rs1 (
        .src_addr   (ex_q.rs1_addr),
        .src_rden   (ex_q.rs1_rden),
        .held_data  (ex_q.rs1_data),
        .wb_rd_wren (wb_rd_wren),
        .wb_rd_addr (wb_rd_addr),
        .wb_rd_data (wb_rd_data),
        .snoop_data (rs1_snoop)
    );

    operand_snoop u_snoop_rs2 (
        .src_addr   (ex_q.rs2_addr),
        .src_rden   (ex_q.rs2_rden),
        .held_data  (ex_q.rs2_data),
        .wb_rd_wren (wb_rd_wren),
        .wb_rd_addr (wb_rd_addr),
        .wb_rd_data (wb_rd_data),
        .snoop_data (rs2_snoop)
    );

    always_comb begin
        ex_d      = ex_q;
        ctrl_d    = ctrl_q;
        valid_d   = valid_q;
        bub_cnt_d = bub_cnt_q;
        if (ex_flush) begin
            valid_d   = 1'b0;
            bub_cnt_d = '0;
        end else if (capture) begin
            ex_d.pc       = id_pc;
            ex_d.instr    = id_instr;
            ex_d.imm      = id_imm;
            ex_d.rd_addr  = id_rd_addr;
            ex_d.rd_wren  = id_rd_wren;
            ex_d.is_load  = id_is_load;
            ex_d.rs1_addr = id_rs1_addr;
            ex_d.rs2_addr = id_rs2_addr;
            ex_d.rs1_rden = id_rs1_rden;
            ex_d.rs2_rden = id_rs2_rden;
            ex_d.rs1_data = rs1_data;
            ex_d.rs2_data = rs2_data;
            ctrl_d        = id_ctrl;
            valid_d       = 1'b1;
        end else begin
            if (handoff) begin
                valid_d = 1'b0;
            end
            if (bub_cnt_q != '0) begin
                bub_cnt_d = bub_cnt_q - bub_cnt_t'(1);
            end else if (load_leaves) begin
                bub_cnt_d = bub_cnt_t'(LOAD_USE_BUBBLES - 1);
            end
            if (hold) begin
                ex_d.rs1_data = rs1_snoop;
                ex_d.rs2_data = rs2_snoop;
            end
        end
        state_d = (bub_cnt_d != '0) ? ST_BUBBLE : ST_RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q      <= '0;
            ctrl_q    <= '0;
            valid_q   <= 1'b0;
            bub_cnt_q <= '0;
            state_q   <= ST_RUN;
        end else begin
            ex_q      <= ex_d;
            ctrl_q    <= ctrl_d;
            valid_q   <= valid_d;
            bub_cnt_q <= bub_cnt_d;
            state_q   <= state_d;
        end
    end

    assign ex_valid    = valid_q;
    assign ex_pc       = ex_q.pc;
    assign ex_instr    = ex_q.instr;
    assign ex_imm      = ex_q.imm;
    assign ex_ctrl     = ctrl_q;
    assign ex_rd_addr  = ex_q.rd_addr;
    assign ex_rd_wren  = ex_q.rd_wren;
    assign ex_is_load  = ex_q.is_load;
    assign ex_rs1_addr = ex_q.rs1_addr;
    assign ex_rs2_addr = ex_q.rs2_addr;
    assign ex_rs1_rden = ex_q.rs1_rden;
    assign ex_rs2_rden = ex_q.rs2_rden;
    assign ex_rs1_data = ex_q.rs1_data;
    assign ex_rs2_data = ex_q.rs2_data;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] perf_bubble_q, perf_bubble_d;
    logic [31:0] perf_flush_q, perf_flush_d;
    logic        bubble_slot;

    // Counted on the cycle that decides EX will sit empty because of a load-use stall.
    assign bubble_slot = !ex_flush && (load_leaves || (state_q == ST_BUBBLE));

    always_comb begin
        perf_bubble_d = perf_bubble_q;
        perf_flush_d  = perf_flush_q;
        if (bubble_slot && (perf_bubble_q != '1)) begin
            perf_bubble_d = perf_bubble_q + 32'd1;
        end
        if (ex_flush && (perf_flush_q != '1)) begin
            perf_flush_d = perf_flush_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_bubble_q <= '0;
            perf_flush_q  <= '0;
        end else begin
            perf_bubble_q <= perf_bubble_d;
            perf_flush_q  <= perf_flush_d;
        end
    end

    assign perf_bubble_cnt = perf_bubble_q;
    assign perf_flush_cnt  = perf_flush_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed bench for id_ex_stage: two instances (1 and 2 load-use bubbles)
// share stimulus and are each compared every cycle against a behavioural pipeline model.
module tb_id_ex_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] imm;
        logic [15:0] ctrl;
        logic [4:0]  rd;
        logic        rd_wren;
        logic        is_load;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        rs1_rden;
        logic        rs2_rden;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        id_valid = 1'b0;
    logic [31:0] id_pc = '0, id_instr = '0, id_imm = '0;
    logic [15:0] id_ctrl = '0;
    logic [4:0]  id_rd_addr = '0, id_rs1_addr = '0, id_rs2_addr = '0;
    logic        id_rd_wren = 1'b0, id_is_load = 1'b0, id_rs1_rden = 1'b0, id_rs2_rden = 1'b0;
    logic [31:0] rs1_data = '0, rs2_data = '0;
    logic        wb_rd_wren = 1'b0;
    logic [4:0]  wb_rd_addr = '0;
    logic [31:0] wb_rd_data = '0;
    logic        ex_flush = 1'b0, ex_ready = 1'b0;

    logic [1:0]        rdy;
    logic [1:0]        vld;
    obs_t [1:0]        obs;
`ifdef ID_EX_PERF_CNT_EN
    logic [1:0][31:0]  perf_b;
    logic [1:0][31:0]  perf_f;
`endif

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [31:0] pc_w, instr_w, imm_w, d1_w, d2_w;
        logic [15:0] ctrl_w;
        logic [4:0]  rd_w, a1_w, a2_w;
        logic        wren_w, ld_w, e1_w, e2_w, rdy_w, vld_w;
`ifdef ID_EX_PERF_CNT_EN
        logic [31:0] pb_w, pf_w;
        assign perf_b[g] = pb_w;
        assign perf_f[g] = pf_w;
`endif

        id_ex_stage #(.LOAD_USE_BUBBLES(g + 1), .CTRL_W(16)) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .id_valid    (id_valid),
            .id_ready    (rdy_w),
            .id_pc       (id_pc),
            .id_instr    (id_instr),
            .id_imm      (id_imm),
            .id_ctrl     (id_ctrl),
            .id_rd_addr  (id_rd_addr),
            .id_rd_wren  (id_rd_wren),
            .id_is_load  (id_is_load),
            .id_rs1_addr (id_rs1_addr),
            .id_rs2_addr (id_rs2_addr),
            .id_rs1_rden (id_rs1_rden),
            .id_rs2_rden (id_rs2_rden),
            .rs1_data    (rs1_data),
            .rs2_data    (rs2_data),
            .wb_rd_wren  (wb_rd_wren),
            .wb_rd_addr  (wb_rd_addr),
            .wb_rd_data  (wb_rd_data),
            .ex_flush    (ex_flush),
            .ex_ready    (ex_ready),
            .ex_valid    (vld_w),
            .ex_pc       (pc_w),
            .ex_instr    (instr_w),
            .ex_imm      (imm_w),
            .ex_ctrl     (ctrl_w),
            .ex_rd_addr  (rd_w),
            .ex_rd_wren  (wren_w),
            .ex_is_load  (ld_w),
            .ex_rs1_addr (a1_w),
            .ex_rs2_addr (a2_w),
            .ex_rs1_rden (e1_w),
            .ex_rs2_rden (e2_w),
            .ex_rs1_data (d1_w),
            .ex_rs2_data (d2_w)
`ifdef ID_EX_PERF_CNT_EN
            ,
            .perf_bubble_cnt (pb_w),
            .perf_flush_cnt  (pf_w)
`endif
        );

        assign rdy[g] = rdy_w;
        assign vld[g] = vld_w;
        assign obs[g] = {pc_w, instr_w, imm_w, ctrl_w, rd_w, wren_w, ld_w, a1_w, a2_w,
                         e1_w, e2_w, d1_w, d2_w};
    end

    // Reference model: what EX holds, whether it is live, and how many empty EX cycles remain.
    obs_t        m_ex    [2];
    logic        m_vld   [2];
    int          m_stall [2];
    logic [31:0] m_pb    [2];
    logic [31:0] m_pf    [2];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic m_haz(input int g);
        logic [4:0] dst;
        dst = m_ex[g].rd;
        if (!m_vld[g] || !m_ex[g].is_load || !m_ex[g].rd_wren || dst == 5'd0) return 1'b0;
        return (id_rs1_rden && id_rs1_addr == dst) || (id_rs2_rden && id_rs2_addr == dst);
    endfunction

    function automatic logic m_ready(input int g);
        if (ex_flush) return 1'b1;
        return (!m_vld[g] || ex_ready) && !m_haz(g) && (m_stall[g] == 0);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic m_reset();
        for (int g = 0; g < 2; g++) begin
            m_ex[g] = '0; m_vld[g] = 1'b0; m_stall[g] = 0; m_pb[g] = '0; m_pf[g] = '0;
        end
    endtask

    task automatic m_advance(input int g);
        logic haz, rd;
        haz = m_haz(g);
        rd  = m_ready(g);
        if (ex_flush) begin
            m_vld[g]   = 1'b0;
            m_stall[g] = 0;
            m_pf[g]    = sat_inc(m_pf[g]);
        end else if (id_valid && rd) begin
            m_ex[g]  = '{id_pc, id_instr, id_imm, id_ctrl, id_rd_addr, id_rd_wren, id_is_load,
                         id_rs1_addr, id_rs2_addr, id_rs1_rden, id_rs2_rden, rs1_data, rs2_data};
            m_vld[g] = 1'b1;
        end else begin
            if (m_stall[g] > 0) begin
                m_stall[g]--;
                m_pb[g] = sat_inc(m_pb[g]);
            end else if (m_vld[g] && ex_ready && haz && id_valid) begin
                m_stall[g] = g;  // instance g inserts g+1 bubbles in total
                m_pb[g]    = sat_inc(m_pb[g]);
            end
            if (m_vld[g] && ex_ready) begin
                m_vld[g] = 1'b0;
            end else if (m_vld[g] && wb_rd_wren && wb_rd_addr != 5'd0) begin
                if (m_ex[g].rs1_rden && m_ex[g].rs1 == wb_rd_addr) m_ex[g].rs1_data = wb_rd_data;
                if (m_ex[g].rs2_rden && m_ex[g].rs2 == wb_rd_addr) m_ex[g].rs2_data = wb_rd_data;
            end
        end
    endtask

    // Called just after a negedge with inputs driven; returns at the next negedge.
    task automatic step();
        logic [1:0] er;
        #1;
        for (int g = 0; g < 2; g++) begin
            er[g] = m_ready(g);
            check($sformatf("id_ready[%0d]", g), 256'(rdy[g]), 256'(er[g]));
        end
        @(posedge clk);
        for (int g = 0; g < 2; g++) m_advance(g);
        #1;
        for (int g = 0; g < 2; g++) begin
            check($sformatf("ex_valid[%0d]", g), 256'(vld[g]), 256'(m_vld[g]));
            if (m_vld[g]) check($sformatf("ex_fields[%0d]", g), 256'(obs[g]), 256'(m_ex[g]));
`ifdef ID_EX_PERF_CNT_EN
            check($sformatf("perf_bubble[%0d]", g), 256'(perf_b[g]), 256'(m_pb[g]));
            check($sformatf("perf_flush[%0d]", g), 256'(perf_f[g]), 256'(m_pf[g]));
`endif
        end
        @(negedge clk);
    endtask

    task automatic idle();
        id_valid = 1'b0; ex_flush = 1'b0; wb_rd_wren = 1'b0; ex_ready = 1'b1;
    endtask

    task automatic set_id(input logic [4:0] rd, input logic wren, input logic ld,
                          input logic [4:0] a1, input logic e1, input logic [4:0] a2,
                          input logic e2, input logic [31:0] d1, input logic [31:0] d2);
        id_valid = 1'b1;
        id_pc = $urandom; id_instr = $urandom; id_imm = $urandom; id_ctrl = 16'($urandom);
        id_rd_addr = rd; id_rd_wren = wren; id_is_load = ld;
        id_rs1_addr = a1; id_rs1_rden = e1; id_rs2_addr = a2; id_rs2_rden = e2;
        rs1_data = d1; rs2_data = d2;
    endtask

    // Entered at a negedge; the reset must clear EX before any clock edge arrives.
    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        #1;
        check("reset_valid", 256'(vld), 256'(2'b00));
        for (int g = 0; g < 2; g++) check($sformatf("reset_fields[%0d]", g), 256'(obs[g]), 256'(0));
        m_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        m_reset();
        @(negedge clk);
        do_reset();

        // Back-to-back ALU stream
        for (int i = 0; i < 6; i++) begin
            set_id(5'(i + 10), 1'b1, 1'b0, 5'(i + 1), 1'b1, 5'(i + 2), 1'b1, $urandom, $urandom);
            ex_ready = 1'b1;
            step();
            check("stream_valid", 256'(vld), 256'(2'b11));
        end

        // Load-use: LW x5 then ADD x6,x5,x1
        idle(); step();
        set_id(5'd5, 1'b1, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, $urandom, $urandom); step();
        set_id(5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 5'd1, 1'b1, $urandom, $urandom);
        #1 check("lu_stall_ready", 256'(rdy), 256'(2'b00));
        step(); check("lu_bubble", 256'(vld), 256'(2'b00));
        step(); check("lu_one_bubble", 256'(vld), 256'(2'b01));
        step(); check("lu_two_bubble", 256'(vld), 256'(2'b11));

        // Hold with writeback snoop on rs1, x0 write ignored on rs2
        idle(); step();
        set_id(5'd8, 1'b1, 1'b0, 5'd7, 1'b1, 5'd0, 1'b1, 32'h11, 32'h0); step();
        id_valid = 1'b0; ex_ready = 1'b0;
        wb_rd_wren = 1'b1; wb_rd_addr = 5'd7; wb_rd_data = 32'hAB; step();
        for (int g = 0; g < 2; g++) check("snoop_rs1", 256'(obs[g].rs1_data), 256'(32'hAB));
        wb_rd_addr = 5'd0; wb_rd_data = 32'hCD; step();
        for (int g = 0; g < 2; g++) check("snoop_x0", 256'(obs[g].rs2_data), 256'(32'h0));

        // Flush while holding with a new instruction offered
        wb_rd_wren = 1'b0;
        set_id(5'd9, 1'b1, 1'b0, 5'd3, 1'b1, 5'd4, 1'b1, $urandom, $urandom);
        ex_flush = 1'b1;
        #1 check("flush_ready", 256'(rdy), 256'(2'b11));
        step(); check("flush_valid", 256'(vld), 256'(2'b00));

        // Flush during a bubble window clears the remaining bubbles
        idle();
        set_id(5'd5, 1'b1, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, $urandom, $urandom); step();
        set_id(5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 5'd1, 1'b1, $urandom, $urandom); step();
        ex_flush = 1'b1; step();
        ex_flush = 1'b0; step(); check("flush_clears_bubble", 256'(vld), 256'(2'b11));

        // x0 load and a non-writing load never stall
        idle(); step();
        set_id(5'd0, 1'b1, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, $urandom, $urandom); step();
        set_id(5'd6, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, $urandom, $urandom);
        #1 check("x0_no_stall", 256'(rdy), 256'(2'b11));
        step();
        set_id(5'd5, 1'b0, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, $urandom, $urandom); step();
        set_id(5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, $urandom, $urandom);
        #1 check("nowren_no_stall", 256'(rdy), 256'(2'b11));
        step();

        // Reset while holding
        set_id(5'd4, 1'b1, 1'b0, 5'd3, 1'b1, 5'd2, 1'b1, $urandom, $urandom); step();
        id_valid = 1'b0; ex_ready = 1'b0; step();
        do_reset();

        // Random traffic with a small register window so hazards and snoops are frequent
        for (int i = 0; i < 3000; i++) begin
            set_id(5'($urandom_range(0, 3)), ($urandom_range(0, 4) != 0), ($urandom_range(0, 2) == 0),
                   5'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
                   5'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0), $urandom, $urandom);
            id_valid   = ($urandom_range(0, 3) != 0);
            ex_ready   = ($urandom_range(0, 4) < 3);
            ex_flush   = ($urandom_range(0, 15) == 0);
            wb_rd_wren = $urandom_range(0, 1) == 1;
            wb_rd_addr = 5'($urandom_range(0, 3));
            wb_rd_data = $urandom;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
